// File: rtl/dcache_ctrl_if.sv
// MEM-stage data-cache bus: CPU lookup/store port, data-memory port and hit-rate counters.
// The controller uses the slave modport; the pipeline/memory side uses master.
interface dcache_ctrl_if;
    logic        state;
    logic        req_load;
    logic        req_store;
    logic [7:0]  req_addr;
    logic [15:0] req_wdata;
    logic        hit;
    logic [15:0] cachedata;
    logic        stall;
    logic        mem_req;
    logic        mem_we;
    logic [7:0]  mem_addr;
    logic [15:0] mem_wdata;
    logic [15:0] mem_rdata;
    logic        mem_ack;
    logic [15:0] access_cnt;
    logic [15:0] miss_cnt;

    modport slave (
        input  state, req_load, req_store, req_addr, req_wdata, mem_rdata, mem_ack,
        output hit, cachedata, stall, mem_req, mem_we, mem_addr, mem_wdata,
        access_cnt, miss_cnt
    );

    modport master (
        output state, req_load, req_store, req_addr, req_wdata, mem_rdata, mem_ack,
        input  hit, cachedata, stall, mem_req, mem_we, mem_addr, mem_wdata,
        access_cnt, miss_cnt
    );
endinterface

// File: rtl/dcache_ctrl.sv
// Direct-mapped, write-through, no-write-allocate data-cache controller (8 lines x 4 words x 16 bits).
// Load misses refill a whole line beat by beat; stores always go to memory and update a hit line.
module dcache_ctrl (
    input  logic          clock,
    input  logic          reset,
    dcache_ctrl_if.slave  bus
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        REFILL = 2'd1,
        WRITE  = 2'd2
    } fsm_t;

    fsm_t        fsm_q, fsm_d;
    logic [7:0]  valid_q, valid_d;
    logic [1:0]  beat_q, beat_d;
    logic [7:0]  addr_q, addr_d;
    logic [15:0] wdata_q, wdata_d;
    logic [15:0] access_q, access_d;
    logic [15:0] miss_q, miss_d;

    logic [2:0]  tag_q  [8];
    logic [15:0] data_q [8][4];

    logic        arr_we;
    logic [1:0]  arr_off;
    logic [15:0] arr_wdata;
    logic        tag_we;

    logic [2:0]  req_tag, lat_tag;
    logic [2:0]  req_idx, lat_idx;
    logic [1:0]  req_off, lat_off;
    logic        lookup_hit;
    logic        lat_line_hit;

    assign req_tag = bus.req_addr[7:5];
    assign req_idx = bus.req_addr[4:2];
    assign req_off = bus.req_addr[1:0];
    assign lat_tag = addr_q[7:5];
    assign lat_idx = addr_q[4:2];
    assign lat_off = addr_q[1:0];

    assign lookup_hit   = valid_q[req_idx] && (tag_q[req_idx] == req_tag);
    assign lat_line_hit = valid_q[lat_idx] && (tag_q[lat_idx] == lat_tag);

    // Lookup is combinational so a hitting load completes with zero latency.
    assign bus.hit        = bus.req_load && lookup_hit && (fsm_q == IDLE);
    assign bus.cachedata  = data_q[req_idx][req_off];
    assign bus.access_cnt = access_q;
    assign bus.miss_cnt   = miss_q;

    always_comb begin
        fsm_d         = fsm_q;
        valid_d       = valid_q;
        beat_d        = beat_q;
        addr_d        = addr_q;
        wdata_d       = wdata_q;
        access_d      = access_q;
        miss_d        = miss_q;
        arr_we        = 1'b0;
        arr_off       = beat_q;
        arr_wdata     = bus.mem_rdata;
        tag_we        = 1'b0;
        bus.stall     = 1'b0;
        bus.mem_req   = 1'b0;
        bus.mem_we    = 1'b0;
        bus.mem_addr  = 8'h00;
        bus.mem_wdata = 16'h0000;

        case (fsm_q)
            IDLE: begin
                if (bus.state) begin
                    if (bus.req_store) begin
                        addr_d    = bus.req_addr;
                        wdata_d   = bus.req_wdata;
                        fsm_d     = WRITE;
                        bus.stall = 1'b1;
                    end else if (bus.req_load) begin
                        if (bus.hit) begin
                            access_d = access_q + 16'd1;
                        end else begin
                            addr_d    = bus.req_addr;
                            beat_d    = 2'd0;
                            miss_d    = miss_q + 16'd1;
                            fsm_d     = REFILL;
                            bus.stall = 1'b1;
                        end
                    end
                end
            end

            REFILL: begin
                bus.stall    = 1'b1;
                bus.mem_req  = 1'b1;
                bus.mem_addr = {addr_q[7:2], beat_q};
                if (bus.mem_ack) begin
                    arr_we = 1'b1;
                    beat_d = beat_q + 2'd1;
                    // The line only becomes valid once every beat has landed.
                    if (beat_q == 2'd3) begin
                        valid_d[lat_idx] = 1'b1;
                        tag_we           = 1'b1;
                        fsm_d            = IDLE;
                    end
                end
            end

            WRITE: begin
                bus.mem_req   = 1'b1;
                bus.mem_we    = 1'b1;
                bus.mem_addr  = addr_q;
                bus.mem_wdata = wdata_q;
                bus.stall     = !bus.mem_ack;
                if (bus.mem_ack) begin
                    if (lat_line_hit) begin
                        arr_we    = 1'b1;
                        arr_off   = lat_off;
                        arr_wdata = wdata_q;
                    end
                    fsm_d = IDLE;
                end
            end

            default: fsm_d = IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            fsm_q    <= IDLE;
            valid_q  <= 8'h00;
            beat_q   <= 2'd0;
            addr_q   <= 8'h00;
            wdata_q  <= 16'h0000;
            access_q <= 16'h0000;
            miss_q   <= 16'h0000;
        end else begin
            fsm_q    <= fsm_d;
            valid_q  <= valid_d;
            beat_q   <= beat_d;
            addr_q   <= addr_d;
            wdata_q  <= wdata_d;
            access_q <= access_d;
            miss_q   <= miss_d;
        end
    end

    // Data and tag storage carry no reset; valid bits alone qualify them.
    always_ff @(posedge clock) begin
        if (arr_we) begin
            data_q[lat_idx][arr_off] <= arr_wdata;
        end
        if (tag_we) begin
            tag_q[lat_idx] <= lat_tag;
        end
    end

endmodule

// File: tb/tb_dcache_ctrl.sv
// Scoreboard bench for dcache_ctrl: a memory responder and a load monitor check the DUT
// against a line-level cache model and a reference memory image.
module tb_dcache_ctrl;
    logic clock = 1'b0;
    logic reset_n;

    always #5 clock = ~clock;

    dcache_ctrl_if bus();

    dcache_ctrl dut (
        .clock (clock),
        .reset (reset_n),
        .bus   (bus)
    );

    typedef struct packed {
        logic        we;
        logic [7:0]  addr;
        logic [15:0] wdata;
    } memop_t;

    typedef struct packed {
        logic [15:0] data;
        logic [31:0] waits;
    } ldexp_t;

    memop_t      exp_mem[$];
    ldexp_t      exp_ld[$];
    logic [15:0] phys_mem [256];
    logic [15:0] ref_mem  [256];
    bit          m_valid  [8];
    logic [2:0]  m_tag    [8];
    int          exp_acc, exp_miss;
    int          ack_delay;
    int          acks_seen;
    int          n_chk, n_fail;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Memory responder: acks after ack_delay extra cycles, checks each request against exp_mem.
    initial begin
        int          cnt;
        logic [7:0]  h_addr;
        logic        h_we;
        logic [15:0] h_wd;
        memop_t      e;
        cnt = 0;
        h_addr = 8'h00;
        h_we = 1'b0;
        h_wd = 16'h0000;
        bus.mem_ack = 1'b0;
        bus.mem_rdata = 16'h0000;
        forever begin
            @(posedge clock);
            #1;
            bus.mem_ack = 1'b0;
            if (!reset_n || !bus.mem_req) begin
                cnt = 0;
            end else begin
                if (cnt == 0) begin
                    h_addr = bus.mem_addr;
                    h_we   = bus.mem_we;
                    h_wd   = bus.mem_wdata;
                end else begin
                    chk("mem_addr_stable", {24'h0, bus.mem_addr}, {24'h0, h_addr});
                    chk("mem_we_stable", {31'h0, bus.mem_we}, {31'h0, h_we});
                    if (h_we) chk("mem_wdata_stable", {16'h0, bus.mem_wdata}, {16'h0, h_wd});
                end
                if (cnt == ack_delay) begin
                    if (exp_mem.size() == 0) begin
                        n_chk++;
                        n_fail++;
                        $display("FAIL unexpected_mem_req: got addr 0x%0h we %0d expected no request",
                                 bus.mem_addr, bus.mem_we);
                    end else begin
                        e = exp_mem.pop_front();
                        chk("mem_we", {31'h0, bus.mem_we}, {31'h0, e.we});
                        chk("mem_addr", {24'h0, bus.mem_addr}, {24'h0, e.addr});
                        if (e.we) chk("mem_wdata", {16'h0, bus.mem_wdata}, {16'h0, e.wdata});
                    end
                    if (bus.mem_we) phys_mem[bus.mem_addr] = bus.mem_wdata;
                    else            bus.mem_rdata = phys_mem[bus.mem_addr];
                    bus.mem_ack = 1'b1;
                    acks_seen++;
                    cnt = 0;
                end else begin
                    cnt++;
                end
            end
        end
    end

    // Load monitor: counts stall cycles of the current load and checks data on its hit cycle.
    initial begin
        int     waits;
        ldexp_t e;
        waits = 0;
        forever begin
            @(negedge clock);
            if (!reset_n) begin
                waits = 0;
            end else if (bus.req_load && bus.state) begin
                if (bus.stall) begin
                    waits++;
                end else if (bus.hit) begin
                    if (exp_ld.size() == 0) begin
                        n_chk++;
                        n_fail++;
                        $display("FAIL unexpected_load_hit: got data 0x%0h expected no load", bus.cachedata);
                    end else begin
                        e = exp_ld.pop_front();
                        chk("load_data", {16'h0, bus.cachedata}, {16'h0, e.data});
                        chk("load_stall_cycles", waits, e.waits);
                    end
                    waits = 0;
                end
            end
        end
    end

    task automatic model_load(input logic [7:0] a);
        logic [2:0] idx;
        logic [2:0] tg;
        bit         hit0;
        ldexp_t     e;
        idx  = a[4:2];
        tg   = a[7:5];
        hit0 = m_valid[idx] && (m_tag[idx] == tg);
        if (!hit0) begin
            for (int b = 0; b < 4; b++) exp_mem.push_back({1'b0, a[7:2], 2'(b), 16'h0000});
            m_valid[idx] = 1'b1;
            m_tag[idx]   = tg;
            exp_miss++;
        end
        exp_acc++;
        e.data  = ref_mem[a];
        e.waits = hit0 ? 0 : 1 + 4 * (ack_delay + 1);
        exp_ld.push_back(e);
    endtask

    task automatic do_load(input logic [7:0] a);
        int n;
        model_load(a);
        @(posedge clock);
        #1;
        bus.req_load = 1'b1;
        bus.req_addr = a;
        n = 0;
        do begin
            @(negedge clock);
            n++;
        end while (!(bus.hit && !bus.stall) && n < 200);
        if (n >= 200) chk("load_timeout", 32'(n), 32'd0);
        @(posedge clock);
        #1;
        bus.req_load = 1'b0;
        chk("access_cnt", {16'h0, bus.access_cnt}, 32'(exp_acc & 16'hFFFF));
        chk("miss_cnt", {16'h0, bus.miss_cnt}, 32'(exp_miss & 16'hFFFF));
    endtask

    task automatic do_store(input logic [7:0] a, input logic [15:0] d);
        int n;
        int stalls;
        exp_mem.push_back({1'b1, a, d});
        ref_mem[a] = d;
        @(posedge clock);
        #1;
        bus.req_store = 1'b1;
        bus.req_addr  = a;
        bus.req_wdata = d;
        n = 0;
        stalls = 0;
        do begin
            @(negedge clock);
            n++;
            if (bus.stall) stalls++;
        end while (bus.stall && n < 200);
        if (n >= 200) chk("store_timeout", 32'(n), 32'd0);
        chk("store_stall_cycles", stalls, 1 + ack_delay);
        @(posedge clock);
        #1;
        bus.req_store = 1'b0;
        chk("access_cnt_store", {16'h0, bus.access_cnt}, 32'(exp_acc & 16'hFFFF));
        chk("miss_cnt_store", {16'h0, bus.miss_cnt}, 32'(exp_miss & 16'hFFFF));
    endtask

    initial begin
        int base;
        int n;
        n_chk = 0;
        n_fail = 0;
        exp_acc = 0;
        exp_miss = 0;
        ack_delay = 0;
        acks_seen = 0;
        for (int i = 0; i < 8; i++) begin
            m_valid[i] = 1'b0;
            m_tag[i] = 3'd0;
        end
        for (int i = 0; i < 256; i++) begin
            phys_mem[i] = 16'($urandom);
            ref_mem[i]  = phys_mem[i];
        end
        for (int i = 0; i < 4; i++) begin
            phys_mem[8'h24 + i] = 16'hA0 + 16'(i);
            ref_mem[8'h24 + i]  = 16'hA0 + 16'(i);
        end
        bus.state = 1'b1;
        bus.req_load = 1'b0;
        bus.req_store = 1'b0;
        bus.req_addr = 8'h00;
        bus.req_wdata = 16'h0000;
        reset_n = 1'b0;

        #22;
        chk("rst_mem_req", {31'h0, bus.mem_req}, 32'd0);
        chk("rst_mem_we", {31'h0, bus.mem_we}, 32'd0);
        chk("rst_mem_addr", {24'h0, bus.mem_addr}, 32'd0);
        chk("rst_mem_wdata", {16'h0, bus.mem_wdata}, 32'd0);
        chk("rst_access_cnt", {16'h0, bus.access_cnt}, 32'd0);
        chk("rst_miss_cnt", {16'h0, bus.miss_cnt}, 32'd0);
        chk("rst_stall", {31'h0, bus.stall}, 32'd0);
        chk("rst_hit", {31'h0, bus.hit}, 32'd0);
        @(negedge clock);
        reset_n = 1'b1;

        // Directed scenarios
        ack_delay = 0;
        do_load(8'h25);
        do_load(8'h26);
        ack_delay = 2;
        do_store(8'h25, 16'h1234);
        ack_delay = 0;
        do_load(8'h25);
        ack_delay = 1;
        do_store(8'hE0, 16'hBEEF);
        do_load(8'hE0);
        ack_delay = 0;
        do_load(8'h45);
        do_load(8'h25);

        // Reset during the third refill beat
        ack_delay = 3;
        for (int b = 0; b < 4; b++) exp_mem.push_back({1'b0, 6'h22, 2'(b), 16'h0000});
        base = acks_seen;
        @(posedge clock);
        #1;
        bus.req_load = 1'b1;
        bus.req_addr = 8'h88;
        n = 0;
        while (acks_seen < base + 2 && n < 100) begin
            @(posedge clock);
            n++;
        end
        chk("refill_acks_before_reset", 32'(acks_seen - base), 32'd2);
        @(posedge clock);
        #3;
        reset_n = 1'b0;
        #1;
        chk("midrst_mem_req", {31'h0, bus.mem_req}, 32'd0);
        chk("midrst_access_cnt", {16'h0, bus.access_cnt}, 32'd0);
        chk("midrst_miss_cnt", {16'h0, bus.miss_cnt}, 32'd0);
        bus.req_load = 1'b0;
        exp_mem.delete();
        for (int i = 0; i < 8; i++) m_valid[i] = 1'b0;
        exp_acc = 0;
        exp_miss = 0;
        #20;
        reset_n = 1'b1;
        ack_delay = 0;
        do_load(8'h8A);

        // CPU not executing: requests are ignored
        @(posedge clock);
        #1;
        bus.state = 1'b0;
        bus.req_load = 1'b1;
        bus.req_addr = 8'hF0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clock);
            chk("halt_load_stall", {31'h0, bus.stall}, 32'd0);
            chk("halt_load_mem_req", {31'h0, bus.mem_req}, 32'd0);
        end
        bus.req_load = 1'b0;
        bus.req_store = 1'b1;
        @(negedge clock);
        chk("halt_store_stall", {31'h0, bus.stall}, 32'd0);
        @(posedge clock);
        #1;
        chk("halt_store_mem_req", {31'h0, bus.mem_req}, 32'd0);
        chk("halt_miss_cnt", {16'h0, bus.miss_cnt}, 32'(exp_miss));
        bus.req_store = 1'b0;
        bus.state = 1'b1;

        // Randomized traffic over a small address footprint so lines hit and conflict
        for (int i = 0; i < 150; i++) begin
            logic [7:0] a;
            ack_delay = $urandom_range(0, 3);
            a = {3'($urandom_range(0, 2)), 3'($urandom_range(0, 3)), 2'($urandom_range(0, 3))};
            if ($urandom_range(0, 9) < 7) do_load(a);
            else                          do_store(a, 16'($urandom));
        end

        repeat (3) @(posedge clock);
        chk("exp_mem_drained", 32'(exp_mem.size()), 32'd0);
        chk("exp_load_drained", 32'(exp_ld.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/dcache_ctrl.md
# dcache_ctrl

Data-cache controller for the MEM stage of the 5-stage pipeline. Sequences a direct-mapped, write-through, no-write-allocate data cache: it answers MEM-stage LOAD/STORE lookups, refills lines from data memory on a load miss, forwards stores to memory, and stalls the pipeline while memory is busy. Its `hit` and `cachedata` outputs feed the MEM stage's load-result mux. It also maintains the load-access and miss counters used for hit-rate measurement.

## Interface
- Parameters: none. Geometry is fixed: 8-bit word address, 8 lines × 4 words × 16 bits, tag = addr[7:5], index = addr[4:2], offset = addr[1:0].
- clock  in  1  pipeline clock; all state changes on its rising edge
- reset  in  1  asynchronous, active-low; clears all state
- state  in  1  CPU run state (1 = exec); new requests are accepted only when 1
- req_load  in  1  MEM stage holds a LOAD
- req_store  in  1  MEM stage holds a STORE
- req_addr  in  8  data word address
- req_wdata  in  16  store data
- hit  out  1  load hits a valid line (combinational)
- cachedata  out  16  cached word at req_addr (combinational; valid when hit=1)
- stall  out  1  freeze the pipeline (combinational)
- mem_req  out  1  memory request, held until mem_ack
- mem_we  out  1  1 = write, 0 = read; qualified by mem_req
- mem_addr  out  8  memory word address
- mem_wdata  out  16  memory write data
- mem_rdata  in  16  memory read data, valid with mem_ack
- mem_ack  in  1  one-cycle completion pulse for the current mem_req
- access_cnt  out  16  retired loads
- miss_cnt  out  16  load misses (refills started)

## Operation
- FSM states: IDLE, REFILL, WRITE.
- Lookup: hit = req_load & valid[index] & (tag_q[index] == tag) & (fsm == IDLE).
- IDLE, state=1:
  - req_store: takes priority if req_load is also set. Latch addr/data and go to WRITE.
  - req_load & !hit: latch addr, set beat=0, go to REFILL, and increment miss_cnt.
  - req_load & hit: no transition. Increment access_cnt.
- IDLE, state=0: requests are ignored, and stall=0.
- REFILL:
  - Drive mem_req=1, mem_we=0, mem_addr={tag,index,beat}.
  - On mem_ack: write mem_rdata into data[index][beat] and increment beat.
  - On the ack for beat 3: set valid[index]=1, tag_q[index]=tag, and return to IDLE. The load then hits in IDLE.
- WRITE:
  - Drive mem_req=1, mem_we=1, mem_addr/mem_wdata from the latched values.
  - On mem_ack: if the line is valid and the tag matches, update data[index][offset] with the store data. Return to IDLE.
  - Miss stores never allocate.
- stall = (IDLE & state & (req_store | (req_load & !hit))) | REFILL | (WRITE & !mem_ack).
- mem_ack outside REFILL/WRITE is ignored. mem_req is 0 in IDLE.
- Counters wrap modulo 2^16. Stores count in neither counter.
- state dropping to 0 mid-transaction does not abort it; the FSM completes and returns to IDLE.

## Timing
- Reset (async, low): fsm=IDLE, all valid=0, beat=0, access_cnt=0, miss_cnt=0, mem_req=0, mem_we=0, mem_addr=0, mem_wdata=0. Data/tag arrays need not be cleared.
- hit, cachedata and stall are combinational in the same cycle as the request: hit latency is 0 and stall=0.
- Load miss:
  - stall rises in the request cycle.
  - REFILL starts next cycle; 4 beats, each lasting ≥1 cycle until its ack.
  - The cycle after the 4th ack shows hit=1, stall=0.
  - With immediate acks: 1 request cycle + 4 refill cycles, then the hit cycle.
- Store: stall=1 in the request cycle and in WRITE until the ack cycle. stall=0 in the ack cycle, so the pipeline advances on that edge.
- mem_addr/mem_we/mem_wdata are stable while mem_req=1 and no ack has been received.
- Reset asserted during REFILL invalidates everything; a partial line never becomes valid.

## Test plan
- Reset, then load 0x25 with acks returning 0xA0..0xA3 on consecutive cycles → mem_addr reads 0x24..0x27, then hit=1, cachedata=0xA1, miss_cnt=1, access_cnt=1, stall high for 5 cycles.
- Load 0x26 after the previous refill → hit=1 in cycle 0, stall=0, cachedata=0xA2, access_cnt=2, no mem_req.
- Store 0x1234 to 0x25 (hit line), ack after 3 cycles → mem_we=1, mem_addr=0x25 held 3 cycles, stall drops in the ack cycle; a following load of 0x25 hits with 0x1234.
- Store to 0xE0 (miss) then load 0xE0 → store does not allocate; the load misses and refills 0xE0..0xE3, miss_cnt increments.
- Load 0x45 (same index as 0x25, different tag) → miss, line replaced; a subsequent load of 0x25 misses again.
- Assert reset during REFILL beat 2 → mem_req=0 immediately, counters=0; a subsequent load of the same address misses.
